// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, opcode constants and fetch-stage state encoding.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 7;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_ITYPE = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE = 7'b0100011;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  // True for the opcodes the controller decodes.
  function automatic logic opc_is_legal(input logic [OPC_W-1:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_ITYPE) ||
           (opc == OPC_LOAD)  || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count; DEPTH must be a power of 2.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

  // Pointers and occupancy; flush empties the queue and wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, buffers responses in order.
// Define FETCH_OPCHECK_EN to drive illegal_op from an opcode checker on the buffer head.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc,
  output logic [OPC_W-1:0]   opcode,
  output logic               illegal_op
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = INSTR_W + XLEN;

  fetch_state_t     r_state;
  logic [XLEN-1:0]  r_pc;
  logic [CNT_W-1:0] r_drop;

  logic [CNT_W-1:0] w_buf_count;
  logic [CNT_W-1:0] w_aq_count;
  logic [ENT_W-1:0] w_buf_head;
  logic [XLEN-1:0]  w_aq_head;
  logic             w_instr_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_req_valid;
  logic             w_accept;
  logic [SUM_W-1:0] w_used;
  logic [CNT_W-1:0] w_inflight;
  logic [CNT_W-1:0] w_drop_nxt;

  assign w_instr_valid = (w_buf_count != '0);
  assign w_pop         = w_instr_valid && instr_ready;
  assign w_push        = (r_state == RUN) && imem_rsp_valid;

  // A same-cycle pop frees a slot, which keeps the pipe bubble-free at depth 2.
  assign w_used      = SUM_W'(w_buf_count) + SUM_W'(w_aq_count) - SUM_W'(w_pop);
  assign w_req_valid = !rst && (r_state == RUN) && !redirect_valid &&
                       (w_used < SUM_W'(FIFO_DEPTH));
  assign w_accept    = w_req_valid && imem_req_ready;

  // In RUN the address queue occupancy is exactly the outstanding request count.
  assign w_inflight = (r_state == RUN) ? w_aq_count : r_drop;
  assign w_drop_nxt = w_inflight - CNT_W'(imem_rsp_valid && (w_inflight != '0));

  fetch_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_instr_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({imem_rsp_data, w_aq_head}),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_data  (w_buf_head),
    .o_count (w_buf_count)
  );

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_addr_q (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_data  (r_pc),
    .i_pop   (w_push),
    .i_flush (redirect_valid),
    .o_data  (w_aq_head),
    .o_count (w_aq_count)
  );

  // PC / flush FSM; leaving FLUSH as soon as the drop count hits zero avoids a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_drop  <= '0;
    end else if (redirect_valid) begin
      r_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      r_drop  <= w_drop_nxt;
      r_state <= (w_drop_nxt != '0) ? FLUSH : RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (w_accept) r_pc <= r_pc + XLEN'(4);
        end
        FLUSH: begin
          if (imem_rsp_valid) begin
            r_drop <= w_drop_nxt;
            if (w_drop_nxt == '0) r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign instr_valid    = w_instr_valid;
  assign instr          = w_instr_valid ? w_buf_head[ENT_W-1 -: INSTR_W] : '0;
  assign instr_pc       = w_instr_valid ? w_buf_head[XLEN-1:0] : '0;
  assign opcode         = instr[OPC_W-1:0];

`ifdef FETCH_OPCHECK_EN
  assign illegal_op = w_instr_valid && !opc_is_legal(opcode);
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order imem responder (1-cycle latency, gateable).
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  logic [31:0] pending[$];
  logic        rsp_en;
  logic        force_en;
  logic [31:0] force_data;
  logic [31:0] exp_illegal;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .illegal_op     (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: upper bits carry the address so stale words are recognisable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[24:0], 7'b0110011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive imem response, record accepted request, advance to just after the edge.
  task automatic tick();
    logic [31:0] a;
    if (rsp_en && pending.size() > 0) begin
      a = pending.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = force_en ? force_data : mem_word(a);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (imem_req_valid && imem_req_ready) pending.push_back(imem_req_addr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    rsp_en         = 1'b1;
    force_en       = 1'b0;
    force_data     = '0;
`ifdef FETCH_OPCHECK_EN
    exp_illegal = 32'd1;
`else
    exp_illegal = 32'd0;
`endif

    repeat (3) tick();
    chk("rst_req_valid",   32'(imem_req_valid), 32'd0);
    chk("rst_req_addr",    imem_req_addr,       32'h0);
    chk("rst_instr_valid", 32'(instr_valid),    32'd0);
    chk("rst_instr",       instr,               32'h0);
    chk("rst_instr_pc",    instr_pc,            32'h0);
    chk("rst_illegal",     32'(illegal_op),     32'd0);

    // Fill and steady-state streaming.
    rst = 1'b0;
    #1;
    chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
    chk("c0_req_addr",  imem_req_addr,       32'h0);
    chk("c0_instr_vld", 32'(instr_valid),    32'd0);
    tick();
    chk("c1_req_addr",  imem_req_addr,       32'h4);
    chk("c1_instr_vld", 32'(instr_valid),    32'd0);
    tick();
    for (int k = 2; k < 8; k++) begin
      chk("stream_valid", 32'(instr_valid), 32'd1);
      chk("stream_pc",    instr_pc,         32'(4 * (k - 2)));
      chk("stream_instr", instr,            mem_word(32'(4 * (k - 2))));
      tick();
    end

    // Downstream stall: credits exhausted, head holds.
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_no_req", 32'(imem_req_valid), 32'd0);
      chk("stall_valid",  32'(instr_valid),    32'd1);
      chk("stall_pc",     instr_pc,            32'h18);
      tick();
    end
    instr_ready = 1'b1;
    #1;
    chk("resume_req_valid", 32'(imem_req_valid), 32'd1);
    chk("resume_req_addr",  imem_req_addr,       32'h20);
    chk("resume_pc0",       instr_pc,            32'h18);
    tick();
    chk("resume_pc1", instr_pc, 32'h1c);
    tick();
    chk("resume_pc2", instr_pc, 32'h20);
    tick();

    // Two requests in flight, then redirect to 0x100.
    rsp_en = 1'b0;
    chk("pre_redir_pc", instr_pc, 32'h24);
    tick();
    chk("redir_empty", 32'(instr_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("redir_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    rsp_en         = 1'b1;
    #1;
    chk("flush1_no_req", 32'(imem_req_valid), 32'd0);
    chk("flush1_valid",  32'(instr_valid),    32'd0);
    chk("flush1_addr",   imem_req_addr,       32'h100);
    tick();
    chk("flush2_no_req", 32'(imem_req_valid), 32'd0);
    chk("flush2_valid",  32'(instr_valid),    32'd0);
    tick();
    chk("run_req_valid", 32'(imem_req_valid), 32'd1);
    chk("run_req_addr",  imem_req_addr,       32'h100);
    tick();
    chk("run_wait_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("tgt_valid", 32'(instr_valid), 32'd1);
    chk("tgt_pc",    instr_pc,         32'h100);
    chk("tgt_instr", instr,            mem_word(32'h100));

    // Misaligned redirect, then a second redirect while flushing.
    instr_ready = 1'b0;
    rsp_en      = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    redirect_pc = 32'h200;
    #1;
    chk("align_addr",   imem_req_addr,       32'h100);
    chk("fl_no_stale",  32'(instr_valid),    32'd0);
    chk("fl_no_req",    32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    rsp_en         = 1'b1;
    instr_ready    = 1'b1;
    #1;
    chk("re2_no_req", 32'(imem_req_valid), 32'd0);
    chk("re2_addr",   imem_req_addr,       32'h200);
    tick();
    chk("re2_req_valid", 32'(imem_req_valid), 32'd1);
    chk("re2_req_addr",  imem_req_addr,       32'h200);
    chk("re2_empty",     32'(instr_valid),    32'd0);
    tick();
    tick();
    chk("re2_pc",    instr_pc, 32'h200);
    chk("re2_instr", instr,    mem_word(32'h200));

    // Redirect with a same-cycle response (discarded), to the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_empty",     32'(instr_valid),    32'd0);
    chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    chk("wrap_req_addr",  imem_req_addr,       32'hFFFF_FFFC);
    tick();
    chk("wrap_next_addr",  imem_req_addr,       32'h0);
    chk("wrap_next_valid", 32'(imem_req_valid), 32'd1);
    tick();
    chk("wrap_pc",    instr_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", instr,    mem_word(32'hFFFF_FFFC));
    tick();

    // Opcode checker.
    chk("op_legal_pc",  instr_pc,          32'h0);
    chk("op_legal_opc", 32'(opcode),       32'h33);
    chk("op_legal_ill", 32'(illegal_op),   32'd0);
    force_en   = 1'b1;
    force_data = 32'h0000_006F;
    tick();
    force_en = 1'b0;
    chk("op_jal_pc",    instr_pc,        32'h4);
    chk("op_jal_instr", instr,           32'h0000_006F);
    chk("op_jal_opc",   32'(opcode),     32'h6F);
    chk("op_jal_ill",   32'(illegal_op), exp_illegal);

    // Reset mid-operation.
    rst = 1'b1;
    pending.delete();
    tick();
    chk("mrst_valid",   32'(instr_valid),    32'd0);
    chk("mrst_no_req",  32'(imem_req_valid), 32'd0);
    chk("mrst_illegal", 32'(illegal_op),     32'd0);
    rst = 1'b0;
    #1;
    chk("mrst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("mrst_req_addr",  imem_req_addr,       32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
